// File: rtl/router_output_arbiter_pkg.sv
// Shared constants and state encoding for the router output-port arbiter.
package router_output_arbiter_pkg;

    // Input port indices as seen by one output port
    localparam int LOCAL = 0;
    localparam int NORTH = 1;
    localparam int SOUTH = 2;
    localparam int EAST  = 3;
    localparam int WEST  = 4;

    localparam int NUM_PORTS = 5;
    localparam int DATA_W    = 4;

    // Flit counter width; packets are at most 15 flits long
    localparam int CNT_W = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_e;

endpackage

// File: rtl/router_output_arbiter_rr_priority_picker.sv
// Round-robin priority picker: returns the first requester found searching
// upward from last_ptr+1, wrapping at NUM_PORTS. Purely combinational.
module rr_priority_picker #(
    parameter int NUM_PORTS = router_output_arbiter_pkg::NUM_PORTS,
    parameter int PTR_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PTR_W-1:0]     last_ptr,
    output logic [NUM_PORTS-1:0] gnt
);

    logic             found;
    logic [PTR_W-1:0] idx;
    int               sum;

    // Walk the ports in rotated order and keep only the first hit
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        sum   = 0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            sum = int'(last_ptr) + i;
            if (sum >= NUM_PORTS) begin
                sum = sum - NUM_PORTS;
            end
            idx = PTR_W'(sum);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/router_output_arbiter.sv
// Output-port arbiter: grants one input FIFO for a whole packet, streams its
// flits to the downstream FIFO with one cycle of write latency, and rotates
// priority between packets.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no owner; pick a requester round-robin when any req is set
// XFER  | granted port owns the output until PKT_LEN flits have moved
module router_output_arbiter
    import router_output_arbiter_pkg::state_e,
           router_output_arbiter_pkg::ST_IDLE,
           router_output_arbiter_pkg::ST_XFER,
           router_output_arbiter_pkg::CNT_W;
#(
    parameter int NUM_PORTS = router_output_arbiter_pkg::NUM_PORTS,
    parameter int DATA_W    = router_output_arbiter_pkg::DATA_W,
    parameter int PKT_LEN   = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_PORTS-1:0]        req,
    input  logic [NUM_PORTS*DATA_W-1:0] flit_in,
    input  logic                        out_full,
    output logic [NUM_PORTS-1:0]        rd_en,
    output logic [NUM_PORTS-1:0]        grant,
    output logic [DATA_W-1:0]           data_out,
    output logic                        write_out,
    output logic                        busy
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    state_e                 state_q, state_d;
    logic [NUM_PORTS-1:0]   grant_q, grant_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [PTR_W-1:0]       last_ptr_q, last_ptr_d;
    logic [DATA_W-1:0]      data_out_q, data_out_d;
    logic                   write_out_q, write_out_d;

    logic [NUM_PORTS-1:0]   pick;
    logic [PTR_W-1:0]       grant_idx;
    logic [DATA_W-1:0]      flit_g;
    logic                   xfer;
    logic                   last_flit;

    rr_priority_picker #(
        .NUM_PORTS (NUM_PORTS),
        .PTR_W     (PTR_W)
    ) u_picker (
        .req      (req),
        .last_ptr (last_ptr_q),
        .gnt      (pick)
    );

    // Index and head flit of the current owner
    always_comb begin
        grant_idx = '0;
        flit_g    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_q[i]) begin
                grant_idx = PTR_W'(i);
                flit_g    = flit_in[i*DATA_W +: DATA_W];
            end
        end
    end

    // A flit moves only when the owner has one and downstream has room
    always_comb begin
        xfer      = (state_q == ST_XFER) && ((req & grant_q) != '0) && !out_full;
        last_flit = (cnt_q == CNT_W'(PKT_LEN - 1));
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req != '0)         state_d = ST_XFER;
            ST_XFER: if (xfer && last_flit) state_d = ST_IDLE;
            default:                        state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; rd_en is zero in reset because grant_q is forced to zero
    always_comb begin
        busy  = (state_q == ST_XFER);
        rd_en = xfer ? grant_q : '0;
    end

    // Grant, flit counter, priority pointer and downstream write path
    always_comb begin
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        last_ptr_d  = last_ptr_q;
        data_out_d  = data_out_q;
        write_out_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req != '0) begin
                    grant_d = pick;
                    cnt_d   = '0;
                end
            end
            ST_XFER: begin
                if (xfer) begin
                    write_out_d = 1'b1;
                    data_out_d  = flit_g;
                    cnt_d       = cnt_q + CNT_W'(1);
                    if (last_flit) begin
                        grant_d    = '0;
                        last_ptr_d = grant_idx;
                    end
                end
            end
            default: begin
                grant_d = '0;
            end
        endcase
    end

    // Datapath registers; pointer resets to the last port so port 0 wins first
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_q     <= '0;
            cnt_q       <= '0;
            last_ptr_q  <= PTR_W'(NUM_PORTS - 1);
            data_out_q  <= '0;
            write_out_q <= 1'b0;
        end else begin
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            last_ptr_q  <= last_ptr_d;
            data_out_q  <= data_out_d;
            write_out_q <= write_out_d;
        end
    end

    assign grant     = grant_q;
    assign data_out  = data_out_q;
    assign write_out = write_out_q;

endmodule

// File: doc/router_output_arbiter.md
ROUTER_OUTPUT_ARBITER -- requirements
Module: router_output_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 5, number of input ports: 0 local, 1 north, 2 south, 3 east, 4 west.
REQ-002 Parameter DATA_W, default 4, flit width in bits.
REQ-003 Parameter PKT_LEN, default 4, flits per packet; legal range 1..15.
REQ-004 Port clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 Port reset  input  1  asynchronous, active-low reset: asserted at 0, released at 1.
REQ-006 Port req  input  NUM_PORTS  bit i = input FIFO i non-empty with head flit routed to this output.
REQ-007 Port flit_in  input  NUM_PORTS*DATA_W  show-ahead head flit of FIFO i at bits [i*DATA_W +: DATA_W].
REQ-008 Port out_full  input  1  downstream FIFO full; no write may be issued while high.
REQ-009 Port rd_en  output  NUM_PORTS  one-hot pop strobe to input FIFO i.
REQ-010 Port grant  output  NUM_PORTS  registered one-hot owner of the output; all zero when idle.
REQ-011 Port data_out  output  DATA_W  registered flit to downstream FIFO.
REQ-012 Port write_out  output  1  registered write strobe to downstream FIFO.
REQ-013 Port busy  output  1  high while in state XFER.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE and XFER.
REQ-015 In IDLE with req nonzero, the block SHALL load grant with the first requesting port found searching upward from last_ptr+1, modulo NUM_PORTS, and enter XFER on the next edge.
REQ-016 In IDLE, out_full SHALL NOT block grant selection.
REQ-017 In IDLE with req zero, the block SHALL remain in IDLE with grant zero.
REQ-018 A transfer SHALL occur in XFER in any cycle where req[g] is 1 and out_full is 0, where g is the granted port.
REQ-019 rd_en SHALL be combinational: rd_en[g] is 1 exactly in transfer cycles, and all other bits are 0.
REQ-020 On each transfer edge, data_out SHALL load flit_in[g] and write_out SHALL load 1; otherwise write_out SHALL load 0 and data_out SHALL hold its value.
REQ-021 Write latency SHALL be one cycle: write_out is high in the cycle after the matching rd_en.
REQ-022 A 4-bit flit counter SHALL clear on entry to XFER and increment on every transfer.
REQ-023 A transfer with counter equal to PKT_LEN-1 SHALL return the FSM to IDLE, clear grant, and set last_ptr to g.
REQ-024 If req[g] drops or out_full rises mid-packet, the block SHALL stall with grant and counter held; no other port may be granted before the packet completes.
REQ-025 If out_full and the last flit coincide, no transfer SHALL occur, and the block SHALL stay in XFER until the flit moves.
REQ-026 A requester winning back-to-back packets SHALL see exactly one IDLE cycle between packets.
REQ-027 With PKT_LEN=1, every transfer SHALL be the last flit.

Reset
REQ-028 While reset is 0, the block SHALL asynchronously force: state IDLE, grant 0, write_out 0, data_out 0, counter 0, busy 0, and last_ptr NUM_PORTS-1, giving port 0 first priority.
REQ-029 rd_en SHALL be 0 during reset.
REQ-030 Reset asserted mid-packet SHALL abandon the packet with no further rd_en; the upstream FIFOs are reset by their own domain.

Structure
REQ-031 A shared package SHALL hold the port-index constants (LOCAL=0, NORTH=1, SOUTH=2, EAST=3, WEST=4), NUM_PORTS, DATA_W, and the state encoding.
REQ-032 The round-robin search SHALL be one combinational sub-module, rr_priority_picker, with inputs req and last_ptr and one-hot output.
REQ-033 The top module SHALL contain only the FSM, counter, pointer, and output registers.

Verification
REQ-034 Scenario: after reset, req=5'b00001, PKT_LEN=4, flits 5,6,B,C -> grant=00001 one cycle later; rd_en on 4 consecutive cycles; write_out high 4 cycles carrying 5,6,B,C; back to IDLE.
REQ-035 Scenario: req=5'b11111 held, from reset -> packets granted in order 0,1,2,3,4,0, with one IDLE cycle between packets.
REQ-036 Scenario: out_full=1 for 3 cycles during flit 2 of west packet (west_in 3,4,7,8) -> rd_en and write_out low for 3 cycles; output sequence still 3,4,7,8; grant stays 10000.
REQ-037 Scenario: req[g] drops for 2 cycles mid-packet while north requests -> no grant change; packet completes; north is granted next.
REQ-038 Scenario: reset asserted asynchronously mid-flit -> all outputs 0 within the same cycle; after release with req=5'b10001, port 0 is granted first.
REQ-039 Scenario: out_full=1 on the last flit -> state stays XFER until out_full=0; then exactly one write and a return to IDLE.
